// File: rtl/conv_buf_sched_if.sv
// Ping-pong scheduler bus: upstream word stream plus the write/run/status
// wires to the two line buffers and the downstream read-select/done outputs.
//   in_valid/in_data/in_ready : upstream stream, transfer = in_valid & in_ready
//   buf_wr/buf_data           : per-buffer write strobe and shared write data
//   buf_run/buf_ready         : per-buffer run enable and idle status
//   rd_sel/map_done           : running-buffer index and end-of-map pulse
// Modports: slave = scheduler, master = upstream source + buffer pair.
interface conv_buf_sched_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NBUF   = 2;

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic [NBUF-1:0]          buf_wr;
    logic signed [DATA_W-1:0] buf_data;
    logic [NBUF-1:0]          buf_run;
    logic [NBUF-1:0]          buf_ready;
    logic                     rd_sel;
    logic                     map_done;

    modport master (
        output in_valid, in_data, buf_ready,
        input  in_ready, buf_wr, buf_data, buf_run, rd_sel, map_done
    );

    modport slave (
        input  in_valid, in_data, buf_ready,
        output in_ready, buf_wr, buf_data, buf_run, rd_sel, map_done
    );
endinterface

// File: rtl/conv_buf_sched.sv
// Double-buffer scheduler: fills two input-map buffers alternately from the
// upstream stream and runs them towards the conv engine strictly in fill order.
// Ports:
//   clk_in  : clock, rising edge
//   rst_n   : synchronous active-low reset
//   bus     : conv_buf_sched_if.slave (stream in, buffer write/run, status)
//   err     : sticky start-timeout flag, present only with SCHED_TMO_EN
// Optional feature macro: SCHED_TMO_EN (run-start timeout watchdog).
module conv_buf_sched #(
    parameter int unsigned NUM_PIX   = 7744,
    parameter int unsigned START_TMO = 16
) (
    input  logic            clk_in,
    input  logic            rst_n,
    conv_buf_sched_if.slave bus
`ifdef SCHED_TMO_EN
    ,
    output logic            err
`endif
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 13;
    localparam int unsigned TMO_W  = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PIX - 1);

    // Parameter range guard: counter and timer widths are fixed.
    if (NUM_PIX < 1 || NUM_PIX > (1 << CNT_W)) begin : g_bad_num_pix
        $error("NUM_PIX out of range for 13-bit write counter");
    end
    if (START_TMO < 1 || START_TMO > (1 << TMO_W)) begin : g_bad_start_tmo
        $error("START_TMO out of range for 5-bit start timer");
    end

    typedef enum logic [2:0] {
        S_EMPTY,
        S_FILLING,
        S_FULL,
        S_RUN_WAIT,
        S_RUNNING
    } buf_state_e;

    buf_state_e              st_q [2];
    buf_state_e              st_d [2];
    logic                    wr_sel_q, wr_sel_d;
    logic                    rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic [1:0]              buf_wr_q, buf_wr_d;
    logic [DATA_W-1:0]       buf_data_q, buf_data_d;
    logic [1:0]              buf_run_q, buf_run_d;
    logic                    map_done_q, map_done_d;
    logic                    xfer;
    logic                    busy;
`ifdef SCHED_TMO_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    err_q, err_d;
`endif

    assign xfer = bus.in_valid & in_ready_q;

    // Next-state: write side owns the EMPTY/FILLING buffer, read side owns
    // the FULL/RUN_WAIT/RUNNING one, so the two updates never collide.
    always_comb begin
        st_d[0]    = st_q[0];
        st_d[1]    = st_q[1];
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        wr_cnt_d   = wr_cnt_q;
        buf_wr_d   = 2'b00;
        buf_data_d = buf_data_q;
        buf_run_d  = buf_run_q;
        map_done_d = 1'b0;
        busy       = (st_q[0] inside {S_RUN_WAIT, S_RUNNING}) ||
                     (st_q[1] inside {S_RUN_WAIT, S_RUNNING});
`ifdef SCHED_TMO_EN
        tmo_d      = '0;
        err_d      = err_q;
`endif

        if (xfer) begin
            buf_wr_d[wr_sel_q] = 1'b1;
            buf_data_d         = bus.in_data;
            if (wr_cnt_q == CNT_LAST) begin
                st_d[wr_sel_q] = S_FULL;
                wr_cnt_d       = '0;
                wr_sel_d       = ~wr_sel_q;
            end else begin
                st_d[wr_sel_q] = S_FILLING;
                wr_cnt_d       = wr_cnt_q + CNT_W'(1);
            end
        end

        case (st_q[rd_sel_q])
            S_FULL: begin
                if (!busy) begin
                    buf_run_d[rd_sel_q] = 1'b1;
                    st_d[rd_sel_q]      = S_RUN_WAIT;
                end
            end
            S_RUN_WAIT: begin
                if (!bus.buf_ready[rd_sel_q]) begin
                    st_d[rd_sel_q] = S_RUNNING;
`ifdef SCHED_TMO_EN
                end else if (tmo_q == TMO_LAST) begin
                    // Buffer never acknowledged the run: drop the map.
                    buf_run_d[rd_sel_q] = 1'b0;
                    st_d[rd_sel_q]      = S_EMPTY;
                    rd_sel_d            = ~rd_sel_q;
                    err_d               = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
`endif
                end
            end
            S_RUNNING: begin
                if (bus.buf_ready[rd_sel_q]) begin
                    buf_run_d[rd_sel_q] = 1'b0;
                    st_d[rd_sel_q]      = S_EMPTY;
                    map_done_d          = 1'b1;
                    rd_sel_d            = ~rd_sel_q;
                end
            end
            default: ;
        endcase

        in_ready_d = (st_d[wr_sel_d] == S_EMPTY) || (st_d[wr_sel_d] == S_FILLING);
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            st_q[0]    <= S_EMPTY;
            st_q[1]    <= S_EMPTY;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            wr_cnt_q   <= '0;
            in_ready_q <= 1'b1;
            buf_wr_q   <= 2'b00;
            buf_data_q <= '0;
            buf_run_q  <= 2'b00;
            map_done_q <= 1'b0;
`ifdef SCHED_TMO_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            st_q[0]    <= st_d[0];
            st_q[1]    <= st_d[1];
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            wr_cnt_q   <= wr_cnt_d;
            in_ready_q <= in_ready_d;
            buf_wr_q   <= buf_wr_d;
            buf_data_q <= buf_data_d;
            buf_run_q  <= buf_run_d;
            map_done_q <= map_done_d;
`ifdef SCHED_TMO_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.buf_wr   = buf_wr_q;
    assign bus.buf_data = buf_data_q;
    assign bus.buf_run  = buf_run_q;
    assign bus.rd_sel   = rd_sel_q;
    assign bus.map_done = map_done_q;
`ifdef SCHED_TMO_EN
    assign err          = err_q;
`endif
endmodule

// File: doc/conv_buf_sched.md
CONV_BUF_SCHED -- requirements
Module: conv_buf_sched

Interface
REQ-001 Parameter NUM_PIX, default 7744, words per input map (one full buffer).
REQ-002 Parameter START_TMO, default 16, max cycles from buf_run rise to buf_ready fall.
REQ-003 clk_in  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  16  upstream word, signed.
REQ-007 in_ready  output  1  scheduler accepts in_data this cycle; a transfer is in_valid & in_ready.
REQ-008 buf_wr  output  2  per-buffer write strobe, one-hot or zero.
REQ-009 buf_data  output  16  write data to both buffers, registered copy of in_data.
REQ-010 buf_run  output  2  per-buffer run enable; high starts and holds the buffer's read sequence.
REQ-011 buf_ready  input  2  per-buffer status; low while buffer streams to the conv engine, high when idle.
REQ-012 rd_sel  output  1  index of buffer currently running; selects downstream mux.
REQ-013 map_done  output  1  one-cycle pulse when a buffer finishes its read sequence.
REQ-014 err  output  1  sticky start-timeout flag; exists only with SCHED_TMO_EN.

Function
REQ-015 Each buffer b SHALL hold a state: EMPTY, FILLING, FULL, RUN_WAIT, RUNNING.
REQ-016 Write side SHALL own at most one FILLING buffer; wr_sel toggles after each completed fill, starting at 0.
REQ-017 in_ready SHALL be 1 iff buffer wr_sel is EMPTY or FILLING.
REQ-018 On transfer: buf_wr[wr_sel]=1 and buf_data=in_data one cycle later (1-cycle latency); EMPTY->FILLING on first word.
REQ-019 Write counter SHALL be 13-bit, count transfers 0..NUM_PIX-1; on word NUM_PIX-1 buffer->FULL, counter->0, wr_sel toggles.
REQ-020 Read side SHALL serve buffers strictly in fill order via rd_sel, starting at 0.
REQ-021 When buffer rd_sel is FULL and no buffer is RUN_WAIT/RUNNING: buf_run[rd_sel]<=1, state->RUN_WAIT next cycle.
REQ-022 RUN_WAIT->RUNNING when buf_ready[rd_sel] samples 0.
REQ-023 RUNNING->EMPTY when buf_ready[rd_sel] samples 1; same cycle buf_run[rd_sel]<=0, map_done<=1, rd_sel toggles.
REQ-024 buf_run SHALL never have both bits set; at most one buffer RUN_WAIT/RUNNING.
REQ-025 A buffer SHALL never be written while RUN_WAIT/RUNNING; buf_wr and buf_run of the same bit never both 1.
REQ-026 Simultaneous fill-complete on one buffer and read-complete on the other: both transitions taken same cycle; new FULL buffer may start run no earlier than the following cycle.
REQ-027 Both buffers FULL: in_ready=0 until a read completes; no data lost or overwritten.
REQ-028 in_valid with in_ready=0 SHALL produce no write and no counter change.

Reset
REQ-029 rst_n=0 sampled on clk_in: both buffers EMPTY, wr_sel=0, rd_sel=0, counter=0.
REQ-030 Outputs during/after reset: in_ready=1, buf_wr=0, buf_data=0, buf_run=0, map_done=0, err=0.
REQ-031 Reset mid-fill or mid-run SHALL abort immediately; partial map discarded; buf_run drops at the reset edge.

Configuration
REQ-032 Macro SCHED_TMO_EN defined: 5-bit timer counts RUN_WAIT cycles; at START_TMO without buf_ready low, buf_run<=0, buffer->EMPTY, rd_sel toggles, err<=1 (sticky until reset), no map_done.
REQ-033 SCHED_TMO_EN undefined: no timer, RUN_WAIT held indefinitely, err port absent.

Verification
REQ-034 Stream 7744 words continuously, buf_ready model drops 3 cycles after run, rises 400 later -> buf_wr[0] x7744, then buf_run[0] rises, map_done once, buffer 0 EMPTY.
REQ-035 Stream 3x7744 words with slow reader (ready low 20000 cycles) -> in_ready=0 after 15488 words until first map_done; buffers run order 0,1,0; data order intact.
REQ-036 Fill buffer 1 finishing in exact cycle buffer 0 read completes -> both transitions occur, buf_run[1] rises next cycle, never both buf_run bits high.
REQ-037 Assert rst_n=0 at word 5000 of a fill and during RUNNING -> all outputs at reset values next cycle; next stream fills buffer 0 from word 0.
REQ-038 SCHED_TMO_EN defined, buf_ready held high after run -> after 16 cycles buf_run=0, err=1, no map_done; undefined -> buf_run stays 1 for 1000 cycles.
